apu_ch1_sweep: RTL
==================

// Module: apu_ch1_sweep
// PURPOSE
//  Channel-1 frequency sweep unit; consumer of the APU register decode strobes ff10/ff13/ff14 and apu_wr.
//  Holds NR10, the 11-bit channel-1 frequency (NR13/NR14[2:0]), the sweep shadow register and the sweep timer.
//  Periodically rewrites the frequency on frame-sequencer sweep ticks; flags overflow so the channel-1 enable logic can shut the channel.
// PARAMETERS
//  FREQ_W    11  frequency/shadow width
//  PERIOD_W  3   NR10 sweep period field width (bits 6:4)
//  SHIFT_W   3   NR10 shift field width (bits 2:0)
// PORTS
//  clk          in   1       APU clock; all state updates on rising edge
//  reset        in   1       synchronous, active-high reset
//  apu_wr       in   1       CPU write qualifier
//  ff10         in   1       NR10 select
//  ff13         in   1       NR13 select
//  ff14         in   1       NR14 select
//  d            in   8       CPU write data
//  sweep_tick   in   1       one-cycle 128 Hz pulse from frame sequencer
//  nr10_q       out  8       NR10 readback, bit7 reads 1
//  freq         out  FREQ_W  current channel-1 frequency
//  trig         out  1       one-cycle pulse: NR14 write with d[7]=1
//  sweep_ovf    out  1       level; channel-1 kill request
//  busy         out  1       FSM not IDLE
// BEHAVIOUR
//  Reset: nr10=0 (nr10_q=8'h80), freq=0, shadow=0, timer=0, sw_en=0, neg_used=0, sweep_ovf=0, trig=0, state=IDLE.
//  Writes (apu_wr & sel, registered next edge): ff10 -> nr10<=d[6:0]; ff13 -> freq[7:0]<=d; ff14 -> freq[10:8]<=d[2:0], trig<=d[7].
//  Calc: delta=shadow>>shift; new = neg ? shadow-delta : shadow+delta, 12-bit; overflow = !neg & new[11].
//  Trigger (cycle after trig): shadow<=freq; timer<=(period==0)?8:period; sw_en<=(period!=0)|(shift!=0);
//    sweep_ovf<=0; neg_used<=0; if shift!=0 go CHECK (overflow check only, no writeback).
//  FSM IDLE/CALC/CHECK:
//    IDLE: on sweep_tick: timer-1; at 1 reload (period==0 ? 8 : period); if reload & sw_en & period!=0 -> CALC.
//    CALC (1 cycle): if overflow -> sweep_ovf<=1, IDLE; else if shift!=0 -> shadow,freq<=new[10:0], -> CHECK; else IDLE.
//    CHECK (1 cycle): recompute from updated shadow; overflow -> sweep_ovf<=1; -> IDLE. No writeback.
//  Latency: sweep_tick at edge N -> freq updated edge N+2, sweep_ovf at N+2 (CALC) or N+3 (CHECK).
//  Any calc with neg=1 sets neg_used.
//  Priority: trigger beats in-flight CALC/CHECK (FSM forced to IDLE or CHECK per trigger rule);
//    CPU freq write same cycle as CALC writeback: CPU byte wins on freq, shadow still takes new.
//  sweep_tick during CALC/CHECK: timer still decrements, no new calc started (dropped).
//  Subtract never underflows (delta<=shadow); shift=0 with neg=0 can overflow from freq>=1024.
//  sweep_ovf held until next trigger or reset.
//  reset mid-calc: everything to reset values on that edge.
// CONFIGURATION
//  APU_SWEEP_NEG_QUIRK_EN defined: ff10 write clearing d[3] while nr10.neg=1 and neg_used=1 sets sweep_ovf next edge.
//  Undefined: NR10 writes never affect sweep_ovf.
// STRUCTURE
//  apu_pkg: state enum {IDLE,CALC,CHECK}; NR10 field localparams (PERIOD_LSB=4, NEG_BIT=3, SHIFT_LSB=0); FREQ_MAX=11'h7FF.
//  Sub-module apu_sweep_calc: combinational shadow,shift,neg -> new[10:0], overflow.
// TESTING
//  Reset: nr10_q=8'h80, freq=0, sweep_ovf=0, busy=0.
//  NR10=0x11, freq=0x400, trigger, 1 tick -> freq=0x600 at N+2; CHECK sees 0x900 -> sweep_ovf=1 at N+3.
//  NR10=0x19 (neg, shift1), freq=0x100, trigger, 2 ticks -> freq 0x080 then 0x040; sweep_ovf stays 0.
//  NR10=0x01, freq=0x7FF, trigger -> sweep_ovf=1 two edges after trig (trigger-time check).
//  NR10=0x21, 1 tick -> no calc; 2nd tick -> calc; CPU write ff13=0x55 in CALC cycle -> freq[7:0]=0x55.
//  Quirk: NR10=0x19, trigger, 1 tick, write NR10=0x11 -> sweep_ovf=1 iff APU_SWEEP_NEG_QUIRK_EN defined.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared types and constants for the APU channel-1 sweep unit.
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CHECK = 2'd2
  } sweep_state_e;

  localparam int PERIOD_LSB = 4;
  localparam int NEG_BIT    = 3;
  localparam int SHIFT_LSB  = 0;

  localparam logic [10:0] FREQ_MAX = 11'h7FF;

  // A period field of zero behaves as eight ticks for the timer.
  function automatic logic [3:0] timer_reload(input logic [2:0] period);
    return (period == 3'd0) ? 4'd8 : {1'b0, period};
  endfunction

endpackage

// File: rtl/apu_sweep_calc.sv
// Combinational sweep arithmetic: shadow +/- (shadow >> shift) with overflow detect.
module apu_sweep_calc #(
  parameter int FREQ_W  = 11,
  parameter int SHIFT_W = 3
) (
  input  logic [FREQ_W-1:0]  i_shadow,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic               i_neg,
  output logic [FREQ_W-1:0]  o_new,
  output logic               o_overflow
);

  logic [FREQ_W-1:0] w_delta;
  logic [FREQ_W:0]   w_sum;

  assign w_delta = i_shadow >> i_shift;

  // Subtraction cannot underflow because delta never exceeds shadow.
  always_comb begin
    if (i_neg) begin
      w_sum = {1'b0, i_shadow} - {1'b0, w_delta};
    end else begin
      w_sum = {1'b0, i_shadow} + {1'b0, w_delta};
    end
  end

  assign o_new      = w_sum[FREQ_W-1:0];
  assign o_overflow = ~i_neg & w_sum[FREQ_W];

endmodule

// File: rtl/apu_sweep.sv
// Channel-1 frequency sweep: NR10/NR13/NR14 state, sweep timer and IDLE/CALC/CHECK FSM.
// Optional macro APU_SWEEP_NEG_QUIRK_EN: clearing NR10.neg after a negate calc kills the channel.
module apu_ch1_sweep
  import apu_pkg::*;
#(
  parameter int FREQ_W   = 11,
  parameter int PERIOD_W = 3,
  parameter int SHIFT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              apu_wr,
  input  logic              ff10,
  input  logic              ff13,
  input  logic              ff14,
  input  logic [7:0]        d,
  input  logic              sweep_tick,
  output logic [7:0]        nr10_q,
  output logic [FREQ_W-1:0] freq,
  output logic              trig,
  output logic              sweep_ovf,
  output logic              busy
);

  logic [6:0]        r_nr10;
  logic [FREQ_W-1:0] r_freq;
  logic [FREQ_W-1:0] r_shadow;
  logic [3:0]        r_timer;
  logic              r_sw_en;
  logic              r_neg_used;
  logic              r_ovf;
  logic              r_trig;
  sweep_state_e      r_state;

  logic [PERIOD_W-1:0] w_period;
  logic [SHIFT_W-1:0]  w_shift;
  logic                w_neg;
  logic                w_wr10;
  logic                w_wr13;
  logic                w_wr14;
  logic                w_reload;
  logic [3:0]          w_reload_val;
  logic [FREQ_W-1:0]   w_new;
  logic                w_overflow;
  logic                w_quirk;

  assign w_period     = r_nr10[PERIOD_LSB +: PERIOD_W];
  assign w_shift      = r_nr10[SHIFT_LSB +: SHIFT_W];
  assign w_neg        = r_nr10[NEG_BIT];
  assign w_wr10       = apu_wr & ff10;
  assign w_wr13       = apu_wr & ff13;
  assign w_wr14       = apu_wr & ff14;
  assign w_reload     = (r_timer <= 4'd1);
  assign w_reload_val = timer_reload(w_period);

`ifdef APU_SWEEP_NEG_QUIRK_EN
  assign w_quirk = w_wr10 & ~d[NEG_BIT] & w_neg & r_neg_used;
`else
  assign w_quirk = 1'b0;
`endif

  apu_sweep_calc #(
    .FREQ_W  (FREQ_W),
    .SHIFT_W (SHIFT_W)
  ) u_calc (
    .i_shadow   (r_shadow),
    .i_shift    (w_shift),
    .i_neg      (w_neg),
    .o_new      (w_new),
    .o_overflow (w_overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nr10     <= 7'd0;
      r_freq     <= '0;
      r_shadow   <= '0;
      r_timer    <= 4'd0;
      r_sw_en    <= 1'b0;
      r_neg_used <= 1'b0;
      r_ovf      <= 1'b0;
      r_trig     <= 1'b0;
      r_state    <= IDLE;
    end else begin
      r_trig <= w_wr14 & d[7];
      if (w_wr10) begin
        r_nr10 <= d[6:0];
      end

      // The timer runs in every state; ticks during CALC/CHECK still count down.
      if (r_trig) begin
        r_timer <= w_reload_val;
      end else if (sweep_tick) begin
        r_timer <= w_reload ? w_reload_val : r_timer - 4'd1;
      end

      if (r_trig) begin
        r_shadow   <= r_freq;
        r_sw_en    <= (w_period != '0) | (w_shift != '0);
        r_ovf      <= 1'b0;
        r_neg_used <= 1'b0;
        r_state    <= (w_shift != '0) ? CHECK : IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (sweep_tick && w_reload && r_sw_en && (w_period != '0)) begin
              r_state <= CALC;
            end
          end
          CALC: begin
            if (w_neg) begin
              r_neg_used <= 1'b1;
            end
            if (w_overflow) begin
              r_ovf   <= 1'b1;
              r_state <= IDLE;
            end else if (w_shift != '0) begin
              r_shadow <= w_new;
              r_freq   <= w_new;
              r_state  <= CHECK;
            end else begin
              r_state <= IDLE;
            end
          end
          CHECK: begin
            if (w_neg) begin
              r_neg_used <= 1'b1;
            end
            if (w_overflow) begin
              r_ovf <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
        if (w_quirk) begin
          r_ovf <= 1'b1;
        end
      end

      // CPU byte writes land after the sweep writeback so they take precedence.
      if (w_wr13) begin
        r_freq[7:0] <= d;
      end
      if (w_wr14) begin
        r_freq[FREQ_W-1:8] <= d[FREQ_W-9:0];
      end
    end
  end

  assign nr10_q    = {1'b1, r_nr10};
  assign freq      = r_freq;
  assign trig      = r_trig;
  assign sweep_ovf = r_ovf;
  assign busy      = (r_state != IDLE);

endmodule
